// File: rtl/alu_pkg.sv
// Shared encodings for the 64-bit ALU and its self-test controller.
package alu_pkg;

   localparam int DATA_W_DEF = 64;

   localparam logic [3:0] ALU_AND   = 4'b0000;
   localparam logic [3:0] ALU_OR    = 4'b0001;
   localparam logic [3:0] ALU_ADD   = 4'b0010;
   localparam logic [3:0] ALU_SUB   = 4'b0110;
   localparam logic [3:0] ALU_PASSB = 4'b0111;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_APPLY = 3'd1,
      S_WAIT  = 3'd2,
      S_CHECK = 3'd3,
      S_DONE  = 3'd4
   } bistState_t;

endpackage

// File: rtl/alu_bist_if.sv
// ALU datapath port bundle: operands/op toward the ALU, result/zero back.
interface alu_bist_if #(
   parameter int DATA_W = 64
);
   logic [DATA_W-1:0] BusA;
   logic [DATA_W-1:0] BusB;
   logic [3:0]        ALUCtrl;
   logic [DATA_W-1:0] BusW;
   logic              Zero;

   modport master (output BusA, BusB, ALUCtrl, input BusW, Zero);
   modport slave  (input BusA, BusB, ALUCtrl, output BusW, Zero);
endinterface

// File: rtl/alu_bist_vectors.sv
// Combinational vector ROM: operands, op and expected result/zero per index.
module alu_bist_vectors
   import alu_pkg::*;
#(
   parameter int DATA_W      = DATA_W_DEF,
   parameter int NUM_VECTORS = 8,
   parameter int IDX_W       = 3
) (
   input  logic [IDX_W-1:0]  idx,
   output logic [DATA_W-1:0] vecA,
   output logic [DATA_W-1:0] vecB,
   output logic [3:0]        vecCtrl,
   output logic [DATA_W-1:0] expW,
   output logic              expZ
);

   always_comb begin
      vecA    = '0;
      vecB    = '0;
      vecCtrl = ALU_AND;
      expW    = '0;
      expZ    = 1'b0;
      case (int'(idx))
         0: begin
            vecA = DATA_W'(1); vecB = DATA_W'(1); vecCtrl = ALU_AND;
            expW = DATA_W'(1); expZ = 1'b0;
         end
         1: begin
            vecA = '0; vecB = '0; vecCtrl = ALU_OR;
            expW = '0; expZ = 1'b1;
         end
         2: begin
            vecA = DATA_W'(2); vecB = DATA_W'(3); vecCtrl = ALU_ADD;
            expW = DATA_W'(5); expZ = 1'b0;
         end
         3: begin
            vecA = DATA_W'(2); vecB = DATA_W'(2); vecCtrl = ALU_SUB;
            expW = '0; expZ = 1'b1;
         end
         4: begin
            vecA = DATA_W'(20); vecB = DATA_W'(20); vecCtrl = ALU_PASSB;
            expW = DATA_W'(20); expZ = 1'b0;
         end
         // carry out of the top bit must be dropped
         5: begin
            vecA = '1; vecB = DATA_W'(1); vecCtrl = ALU_ADD;
            expW = '0; expZ = 1'b1;
         end
         6: begin
            vecA = '0; vecB = DATA_W'(1); vecCtrl = ALU_SUB;
            expW = '1; expZ = 1'b0;
         end
         7: begin
            vecA = {(DATA_W/2){2'b10}}; vecB = {(DATA_W/2){2'b01}}; vecCtrl = ALU_AND;
            expW = '0; expZ = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/alu_bist.sv
// ALU self-test controller: walks the vector ROM, waits for the ALU to settle,
// and tallies matches/mismatches of BusW and Zero.
module alu_bist
   import alu_pkg::*;
#(
   parameter int DATA_W        = DATA_W_DEF,
   parameter int NUM_VECTORS   = 8,
   parameter int SETTLE_CYCLES = 1,
   parameter int IDX_W         = $clog2(NUM_VECTORS)
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Start,
   alu_bist_if.master       alu,
   output logic             Busy,
   output logic             Done,
   output logic [7:0]       PassCount,
   output logic [7:0]       FailCount,
   output logic             FailSeen,
   output logic [IDX_W-1:0] FirstFail,
   output logic             AllPassed
);

   localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;

   // 8-bit tallies must be able to hold the whole table
   if (NUM_VECTORS < 1 || NUM_VECTORS > 255) begin : gBadNumVectors
      $error("alu_bist: NUM_VECTORS must be in 1..255");
   end
   if ((1 << IDX_W) < NUM_VECTORS) begin : gBadIdxW
      $error("alu_bist: IDX_W too narrow for NUM_VECTORS");
   end

   bistState_t        state, stateNext;
   logic [DATA_W-1:0] busA, busANext;
   logic [DATA_W-1:0] busB, busBNext;
   logic [3:0]        ctrl, ctrlNext;
   logic [IDX_W-1:0]  idx, idxNext;
   logic [IDX_W-1:0]  firstFail, firstFailNext;
   logic [CNT_W-1:0]  settle, settleNext;
   logic [7:0]        passCnt, passCntNext;
   logic [7:0]        failCnt, failCntNext;
   logic              failSeen, failSeenNext;

   logic [DATA_W-1:0] romA, romB, romW;
   logic [3:0]        romCtrl;
   logic              romZ;
   logic              match;

   alu_bist_vectors #(
      .DATA_W      (DATA_W),
      .NUM_VECTORS (NUM_VECTORS),
      .IDX_W       (IDX_W)
   ) uRom (
      .idx     (idx),
      .vecA    (romA),
      .vecB    (romB),
      .vecCtrl (romCtrl),
      .expW    (romW),
      .expZ    (romZ)
   );

   // ALU is combinational outside this block, so results are sampled directly
   assign match = (alu.BusW == romW) && (alu.Zero == romZ);

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state     <= S_IDLE;
         busA      <= '0;
         busB      <= '0;
         ctrl      <= '0;
         idx       <= '0;
         firstFail <= '0;
         settle    <= '0;
         passCnt   <= '0;
         failCnt   <= '0;
         failSeen  <= 1'b0;
      end else begin
         state     <= stateNext;
         busA      <= busANext;
         busB      <= busBNext;
         ctrl      <= ctrlNext;
         idx       <= idxNext;
         firstFail <= firstFailNext;
         settle    <= settleNext;
         passCnt   <= passCntNext;
         failCnt   <= failCntNext;
         failSeen  <= failSeenNext;
      end
   end

   always_comb begin
      stateNext     = state;
      busANext      = busA;
      busBNext      = busB;
      ctrlNext      = ctrl;
      idxNext       = idx;
      firstFailNext = firstFail;
      settleNext    = settle;
      passCntNext   = passCnt;
      failCntNext   = failCnt;
      failSeenNext  = failSeen;
      case (state)
         // operand buses are left alone here so DONE keeps showing the last vector
         S_IDLE, S_DONE: begin
            if (Start) begin
               passCntNext   = '0;
               failCntNext   = '0;
               failSeenNext  = 1'b0;
               firstFailNext = '0;
               idxNext       = '0;
               stateNext     = S_APPLY;
            end
         end
         S_APPLY: begin
            busANext   = romA;
            busBNext   = romB;
            ctrlNext   = romCtrl;
            settleNext = CNT_W'(SETTLE_CYCLES);
            stateNext  = (SETTLE_CYCLES > 0) ? S_WAIT : S_CHECK;
         end
         S_WAIT: begin
            settleNext = settle - CNT_W'(1);
            if (settle <= CNT_W'(1)) stateNext = S_CHECK;
         end
         S_CHECK: begin
            if (match) begin
               passCntNext = passCnt + 8'd1;
            end else begin
               failCntNext = failCnt + 8'd1;
               if (!failSeen) begin
                  firstFailNext = idx;
                  failSeenNext  = 1'b1;
               end
            end
            if (idx == IDX_W'(NUM_VECTORS - 1)) begin
               stateNext = S_DONE;
            end else begin
               idxNext   = idx + IDX_W'(1);
               stateNext = S_APPLY;
            end
         end
         default: stateNext = S_IDLE;
      endcase
   end

   assign alu.BusA    = busA;
   assign alu.BusB    = busB;
   assign alu.ALUCtrl = ctrl;

   assign Busy      = (state == S_APPLY) || (state == S_WAIT) || (state == S_CHECK);
   assign Done      = (state == S_DONE);
   assign PassCount = passCnt;
   assign FailCount = failCnt;
   assign FailSeen  = failSeen;
   assign FirstFail = firstFail;
   assign AllPassed = Done && (failCnt == 8'd0);

endmodule
